hazard_track_unit: RTL and testbench

Pipeline hazard tracker sitting beside the ID/EX stage register, consuming the same decoded fields that register captures (src1, src2, is_two_source, dst, write-back enable, memory read). It keeps its own shadow scoreboard of the instructions in the EX, MEM and WB stages. From that scoreboard it drives:
- the IF/ID freeze;
- the bubble-insert request for the ID/EX register;
- EX-stage operand forwarding selects.

---
 rtl/hazard_track_unit_if.sv | 35 +++
 rtl/hazard_track_unit.sv | 122 ++++++++++++
 tb/tb_hazard_track_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_track_unit_if.sv
// hazard_track_unit_if
//   Bundles the decoded ID-stage fields, the EX-stage flush, and the hazard
//   responses exchanged between the pipeline (master) and the hazard
//   tracker (slave).
//   master : drives id_* fields and flush, observes freeze/bubble/fwd/stall_count
//   slave  : the tracker; consumes id_* and flush, produces the responses
interface hazard_track_unit_if #(
  parameter int SAT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       id_dst;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             flush;
  logic             freeze;
  logic             bubble;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic [SAT_W-1:0] stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dst, id_wb_en,
           id_mem_read, flush,
    input  freeze, bubble, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dst, id_wb_en,
           id_mem_read, flush,
    output freeze, bubble, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_track_unit.sv
// hazard_track_unit
//   Shadow scoreboard of the EX, MEM and WB stages kept beside the ID/EX
//   register. Drives the IF/ID freeze, the ID/EX bubble request, the EX
//   operand forwarding selects and a saturating count of freeze cycles.
//   Ports:
//     clk : pipeline clock, all state on the rising edge
//     rst : asynchronous reset, active-low
//     hz  : hazard_track_unit_if.slave (id_* fields, flush in;
//           freeze, bubble, fwd_sel1/2, stall_count out)
//   Build option:
//     FORWARDING_EN defined   -> load-use-only stall, forwarding selects live
//     FORWARDING_EN undefined -> stall on any EX/MEM producer, selects tied 00
//   Slot registers: _p0 = EX, _p1 = MEM, _p2 = WB.
module hazard_track_unit #(
  parameter int SAT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_track_unit_if.slave  hz
);

  function automatic logic src_hit(input logic [4:0] s, input logic vld,
                                   input logic wb_en, input logic [4:0] dst);
    return vld & wb_en & (dst == s) & (s != 5'd0);
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             vld_p0, vld_p1;
  logic [4:0]       dst_p0, dst_p1;
  logic             wb_en_p0, wb_en_p1;
  // Only the EX slot's load flag is consulted (load-use); MEM/WB copies
  // would have no reader.
  logic             mem_rd_p0;
  logic [SAT_W-1:0] cnt_q;
  logic             stall;
  logic             load_ex;
  logic             ex_hit;

  assign ex_hit = src_hit(hz.id_src1, vld_p0, wb_en_p0, dst_p0)
                | (hz.id_two_src & src_hit(hz.id_src2, vld_p0, wb_en_p0, dst_p0));

`ifdef FORWARDING_EN
  logic             vld_p2;
  logic [4:0]       dst_p2;
  logic             wb_en_p2;
  logic [4:0]       src1_p0, src2_p0;
  logic             two_src_p0;

  // With forwarding only a load in EX cannot be bypassed in time.
  assign stall = hz.id_valid & ~hz.flush & ex_hit & mem_rd_p0;

  function automatic logic [1:0] fwd_pick(input logic [4:0] s, input logic use_s,
                                          input logic ex_vld,
                                          input logic m_vld, input logic m_we,
                                          input logic [4:0] m_dst,
                                          input logic w_vld, input logic w_we,
                                          input logic [4:0] w_dst);
    if (!ex_vld || !use_s)                 return 2'b00;
    if (src_hit(s, m_vld, m_we, m_dst))    return 2'b01;
    if (src_hit(s, w_vld, w_we, w_dst))    return 2'b10;
    return 2'b00;
  endfunction

  assign hz.fwd_sel1 = fwd_pick(src1_p0, 1'b1, vld_p0, vld_p1, wb_en_p1, dst_p1,
                                vld_p2, wb_en_p2, dst_p2);
  assign hz.fwd_sel2 = fwd_pick(src2_p0, two_src_p0, vld_p0, vld_p1, wb_en_p1,
                                dst_p1, vld_p2, wb_en_p2, dst_p2);
`else
  logic             mem_hit;

  assign mem_hit = src_hit(hz.id_src1, vld_p1, wb_en_p1, dst_p1)
                 | (hz.id_two_src & src_hit(hz.id_src2, vld_p1, wb_en_p1, dst_p1));
  assign stall   = hz.id_valid & ~hz.flush & (ex_hit | mem_hit);

  assign hz.fwd_sel1 = 2'b00;
  assign hz.fwd_sel2 = 2'b00;
`endif

  assign load_ex        = hz.id_valid & ~stall & ~hz.flush;
  assign hz.freeze      = stall;
  assign hz.bubble      = stall;
  assign hz.stall_count = cnt_q;

  // ID -> EX -> MEM -> WB slot valids and freeze counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
`ifdef FORWARDING_EN
      vld_p2 <= 1'b0;
`endif
      cnt_q  <= '0;
    end else begin
      vld_p0 <= load_ex;
      vld_p1 <= vld_p0;
`ifdef FORWARDING_EN
      vld_p2 <= vld_p1;
`endif
      cnt_q  <= stall ? sat_inc(cnt_q) : cnt_q;
    end
  end

  // ID -> EX -> MEM -> WB slot payload; a bubble loads all zeros
  always_ff @(posedge clk) begin
    dst_p0     <= load_ex ? hz.id_dst : 5'd0;
    wb_en_p0   <= load_ex & hz.id_wb_en;
    mem_rd_p0  <= load_ex & hz.id_mem_read;
    dst_p1     <= dst_p0;
    wb_en_p1   <= wb_en_p0;
`ifdef FORWARDING_EN
    src1_p0    <= load_ex ? hz.id_src1 : 5'd0;
    src2_p0    <= load_ex ? hz.id_src2 : 5'd0;
    two_src_p0 <= load_ex & hz.id_two_src;
    dst_p2     <= dst_p1;
    wb_en_p2   <= wb_en_p1;
`endif
  end

endmodule

// File: tb/tb_hazard_track_unit.sv
module tb_hazard_track_unit;
  localparam int SAT_W = 4;
  localparam int CMAX  = (1 << SAT_W) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_track_unit_if #(.SAT_W(SAT_W)) hz ();
  hazard_track_unit #(.SAT_W(SAT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit       v;
    bit [4:0] dst;
    bit       wb;
    bit       mr;
    bit [4:0] s1;
    bit [4:0] s2;
    bit       two;
  } ins_t;

  // model pipeline: [0]=EX, [1]=MEM, [2]=WB
  ins_t pipe [3];
  int   cnt_m;

  function automatic ins_t empty_ins();
    ins_t e;
    e.v = 0; e.dst = 0; e.wb = 0; e.mr = 0; e.s1 = 0; e.s2 = 0; e.two = 0;
    return e;
  endfunction

  function automatic bit writes_to(ins_t w, bit [4:0] s);
    return w.v && w.wb && (w.dst == s) && (s != 0);
  endfunction

  function automatic bit depends(ins_t r, ins_t w);
    return writes_to(w, r.s1) || (r.two && writes_to(w, r.s2));
  endfunction

  function automatic ins_t cur_id();
    ins_t i;
    i.v = hz.id_valid; i.dst = hz.id_dst; i.wb = hz.id_wb_en;
    i.mr = hz.id_mem_read; i.s1 = hz.id_src1; i.s2 = hz.id_src2;
    i.two = hz.id_two_src;
    return i;
  endfunction

  function automatic bit m_stall();
    ins_t id = cur_id();
    if (!id.v || hz.flush || !rst) return 0;
    if (FWD) return depends(id, pipe[0]) && pipe[0].mr;
    return depends(id, pipe[0]) || depends(id, pipe[1]);
  endfunction

  function automatic bit [1:0] m_fwd(bit [4:0] s, bit use_s);
    if (!FWD || !pipe[0].v || !use_s) return 2'b00;
    if (writes_to(pipe[1], s)) return 2'b01;
    if (writes_to(pipe[2], s)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = empty_ins();
    cnt_m = 0;
  endfunction

  task automatic drive(input bit v, input bit [4:0] s1, input bit [4:0] s2,
                       input bit two, input bit [4:0] dst, input bit wb,
                       input bit mr, input bit fl);
    hz.id_valid = v; hz.id_src1 = s1; hz.id_src2 = s2; hz.id_two_src = two;
    hz.id_dst = dst; hz.id_wb_en = wb; hz.id_mem_read = mr; hz.flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // advance one clock; model follows the pipeline rules
  task automatic tick();
    bit   st = m_stall();
    ins_t id = cur_id();
    bit   fl = hz.flush;
    @(posedge clk);
    if (!rst) model_clear();
    else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id.v && !st && !fl) ? id : empty_ins();
      if (st && cnt_m < CMAX) cnt_m++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    model_clear();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    model_clear();
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL reset_freeze: got %b want 0", hz.freeze); end
    n_cmp++; if (hz.bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble: got %b want 0", hz.bubble); end
    n_cmp++; if ({hz.fwd_sel1, hz.fwd_sel2} !== 4'b0) begin n_bad++; $display("FAIL reset_fwd: got %b%b want 0000", hz.fwd_sel1, hz.fwd_sel2); end
    n_cmp++; if (hz.stall_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", hz.stall_count); end
    tick();
    tick();
    rst = 1'b1;
    drive(1, 3, 0, 0, 8, 1, 0, 0);
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL post_reset_src3: got %b want 0", hz.freeze); end
    tick();
    idle();
  endtask

  // writer then dependent reader; count freeze cycles and check reader's EX selects
  task automatic test_dependency(input string nm, input bit w_mr, input bit [4:0] wdst,
                                 input bit [4:0] rs1, input bit [4:0] rs2, input bit rtwo,
                                 input int exp_cycles);
    int k = 0;
    do_reset();
    drive(1, 1, 2, 1, wdst, 1, w_mr, 0);
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL %s_writer_freeze: got %b want 0", nm, hz.freeze); end
    tick();
    drive(1, rs1, rs2, rtwo, 12, 1, 0, 0);
    while (hz.freeze === 1'b1 && k < 10) begin
      n_cmp++; if (hz.bubble !== m_stall()) begin n_bad++; $display("FAIL %s_bubble: got %b want %b", nm, hz.bubble, m_stall()); end
      tick();
      k++;
    end
    n_cmp++; if (k != exp_cycles) begin n_bad++; $display("FAIL %s_freeze_cycles: got %0d want %0d", nm, k, exp_cycles); end
    tick();
    idle();
    n_cmp++; if (hz.fwd_sel1 !== m_fwd(rs1, 1'b1)) begin n_bad++; $display("FAIL %s_fwd1: got %b want %b", nm, hz.fwd_sel1, m_fwd(rs1, 1'b1)); end
    n_cmp++; if (hz.fwd_sel2 !== m_fwd(rs2, rtwo)) begin n_bad++; $display("FAIL %s_fwd2: got %b want %b", nm, hz.fwd_sel2, m_fwd(rs2, rtwo)); end
    n_cmp++; if (hz.stall_count !== SAT_W'(exp_cycles)) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", nm, hz.stall_count, exp_cycles); end
    if (!FWD) begin
      n_cmp++; if (hz.fwd_sel2 !== 2'b00) begin n_bad++; $display("FAIL %s_fwd2_off: got %b want 00", nm, hz.fwd_sel2); end
    end
  endtask

  task automatic test_r0_two_src();
    do_reset();
    drive(1, 1, 1, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0, 6, 1, 0, 0);
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL r0_freeze: got %b want 0", hz.freeze); end
    tick();
    drive(1, 1, 1, 0, 4, 1, 1, 0);
    tick();
    drive(1, 2, 4, 0, 6, 1, 0, 0);
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL two_src_freeze: got %b want 0", hz.freeze); end
    tick();
    idle();
    n_cmp++; if (hz.fwd_sel2 !== 2'b00) begin n_bad++; $display("FAIL two_src_fwd2: got %b want 00", hz.fwd_sel2); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 2, 0, 9, 1, 1, 0);
    tick();
    drive(1, 9, 9, 1, 10, 1, 0, 1);
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL flush_freeze: got %b want 0", hz.freeze); end
    n_cmp++; if (hz.bubble !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got %b want 0", hz.bubble); end
    tick();
    idle();
    n_cmp++; if ({hz.fwd_sel1, hz.fwd_sel2} !== 4'b0) begin n_bad++; $display("FAIL flush_fwd: got %b%b want 0000", hz.fwd_sel1, hz.fwd_sel2); end
    n_cmp++; if (hz.stall_count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", hz.stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 2, 0, 11, 1, 1, 0);
    tick();
    drive(1, 11, 0, 0, 12, 1, 0, 0);
    n_cmp++; if (hz.freeze !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_freeze: got %b want 1", hz.freeze); end
    rst = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (hz.freeze !== 1'b0) begin n_bad++; $display("FAIL midrst_freeze: got %b want 0", hz.freeze); end
    n_cmp++; if (hz.bubble !== 1'b0) begin n_bad++; $display("FAIL midrst_bubble: got %b want 0", hz.bubble); end
    n_cmp++; if (hz.stall_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", hz.stall_count); end
    tick();
    rst = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    int total = 0;
    int guard = 0;
    do_reset();
    while (total < 20 && guard < 40) begin
      drive(1, 0, 0, 0, 5'(1 + guard % 30), 1, 1, 0);
      tick();
      drive(1, 5'(1 + guard % 30), 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4 && hz.freeze === 1'b1; k++) begin
        total++;
        tick();
      end
      tick();
      idle();
      n_cmp++; if (hz.stall_count !== SAT_W'(cnt_m)) begin n_bad++; $display("FAIL sat_step: got %0d want %0d", hz.stall_count, cnt_m); end
      guard++;
    end
    n_cmp++; if (total < 20) begin n_bad++; $display("FAIL sat_freezes: got %0d want >=20", total); end
    n_cmp++; if (hz.stall_count !== SAT_W'(CMAX)) begin n_bad++; $display("FAIL sat_final: got %0d want %0d", hz.stall_count, CMAX); end
  endtask

  task automatic test_random();
    bit v, two, wb, mr, fl;
    bit [4:0] s1, s2, dst;
    do_reset();
    v = 0; two = 0; wb = 0; mr = 0; s1 = 0; s2 = 0; dst = 0;
    for (int c = 0; c < 400; c++) begin
      if (hz.freeze !== 1'b1) begin
        v   = ($urandom % 10) < 8;
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        dst = 5'($urandom_range(0, 7));
        two = $urandom % 2;
        wb  = ($urandom % 4) != 0;
        mr  = ($urandom % 3) == 0;
      end
      fl = ($urandom % 10) == 0;
      drive(v, s1, s2, two, dst, wb, mr, fl);
      n_cmp++; if (hz.freeze !== m_stall()) begin n_bad++; $display("FAIL rnd_freeze c=%0d: got %b want %b", c, hz.freeze, m_stall()); end
      n_cmp++; if (hz.bubble !== m_stall()) begin n_bad++; $display("FAIL rnd_bubble c=%0d: got %b want %b", c, hz.bubble, m_stall()); end
      n_cmp++; if (hz.fwd_sel1 !== m_fwd(pipe[0].s1, 1'b1)) begin n_bad++; $display("FAIL rnd_fwd1 c=%0d: got %b want %b", c, hz.fwd_sel1, m_fwd(pipe[0].s1, 1'b1)); end
      n_cmp++; if (hz.fwd_sel2 !== m_fwd(pipe[0].s2, pipe[0].two)) begin n_bad++; $display("FAIL rnd_fwd2 c=%0d: got %b want %b", c, hz.fwd_sel2, m_fwd(pipe[0].s2, pipe[0].two)); end
      n_cmp++; if (hz.stall_count !== SAT_W'(cnt_m)) begin n_bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, hz.stall_count, cnt_m); end
      if (fl) v = 0;
      tick();
    end
    idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_dependency("load_use", 1'b1, 5, 5, 0, 1'b0, FWD ? 1 : 2);
    test_dependency("add_sub", 1'b0, 7, 1, 7, 1'b1, FWD ? 0 : 2);
    test_r0_two_src();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
